// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity codes and helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_ODD  = 2'd1;
  localparam logic [1:0] PARITY_EVEN = 2'd2;

  // Code 3 is reserved and behaves as no parity.
  function automatic logic [1:0] parity_decode(input logic [1:0] code);
    case (code)
      PARITY_ODD:  return PARITY_ODD;
      PARITY_EVEN: return PARITY_EVEN;
      default:     return PARITY_NONE;
    endcase
  endfunction

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for asynchronous line inputs; flops reset to 1 (idle line level).
module uart_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1/8E1/8O1), LSB-first, centre sampled, one-cycle data_valid strobe.
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each bit centre.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT  = 434,
  parameter int DATA_BITS       = 8,
  parameter int CLOCK_CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 input_data_serial,
  input  logic [1:0]           parity_type,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 data_valid,
  output logic                 parity_error,
  output logic                 frame_error
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [CLOCK_CTR_WIDTH-1:0] BIT_END = CLOCK_CTR_WIDTH'(CLOCKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  // Start decision one cycle after the centre; data windows then sit at BIT_END-2..BIT_END.
  localparam logic [CLOCK_CTR_WIDTH-1:0] START_END = CLOCK_CTR_WIDTH'((CLOCKS_PER_BIT - 1) / 2 + 1);
`else
  localparam logic [CLOCK_CTR_WIDTH-1:0] START_END = CLOCK_CTR_WIDTH'((CLOCKS_PER_BIT - 1) / 2);
`endif

  rx_state_t                  state, state_next;
  logic                       rx_s;
  logic                       sample_bit;
  logic [CLOCK_CTR_WIDTH-1:0] clk_ctr;
  logic [IDX_W-1:0]           bit_idx;
  logic [DATA_BITS-1:0]       shift_reg;
  logic [1:0]                 parity_reg;
  logic                       par_mis;
  logic                       parity_en;
  logic                       exp_par;

  logic ctr_clr, idx_clr, latch_par, sample_data, sample_par, frame_done;

  uart_sync #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (input_data_serial),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] rx_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_hist <= '1;
    else        rx_hist <= {rx_hist[0], rx_s};
  end

  assign sample_bit = majority3({rx_hist, rx_s});
`else
  assign sample_bit = rx_s;
`endif

  assign parity_en = (parity_reg != PARITY_NONE);
  assign exp_par   = (parity_reg == PARITY_EVEN) ? ^shift_reg : ~^shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    ctr_clr     = 1'b0;
    idx_clr     = 1'b0;
    latch_par   = 1'b0;
    sample_data = 1'b0;
    sample_par  = 1'b0;
    frame_done  = 1'b0;
    case (state)
      RX_IDLE: begin
        ctr_clr = 1'b1;
        idx_clr = 1'b1;
        if (!rx_s) begin
          latch_par  = 1'b1;
          state_next = RX_START;
        end
      end
      RX_START: begin
        if (clk_ctr == START_END) begin
          ctr_clr    = 1'b1;
          state_next = sample_bit ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (clk_ctr == BIT_END) begin
          ctr_clr     = 1'b1;
          sample_data = 1'b1;
          if (bit_idx == LAST_IDX) state_next = parity_en ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (clk_ctr == BIT_END) begin
          ctr_clr    = 1'b1;
          sample_par = 1'b1;
          state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clk_ctr == BIT_END) begin
          ctr_clr    = 1'b1;
          frame_done = 1'b1;
          state_next = RX_IDLE;
        end
      end
      default: begin
        ctr_clr    = 1'b1;
        idx_clr    = 1'b1;
        state_next = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_ctr      <= '0;
      bit_idx      <= '0;
      shift_reg    <= '0;
      parity_reg   <= PARITY_NONE;
      par_mis      <= 1'b0;
      out_data     <= '0;
      data_valid   <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      data_valid <= frame_done;

      if (ctr_clr) clk_ctr <= '0;
      else         clk_ctr <= clk_ctr + CLOCK_CTR_WIDTH'(1);

      if (idx_clr)          bit_idx <= '0;
      else if (sample_data) bit_idx <= bit_idx + IDX_W'(1);

      if (latch_par) begin
        parity_reg <= parity_decode(parity_type);
        par_mis    <= 1'b0;
      end

      if (sample_data) shift_reg[bit_idx] <= sample_bit;
      if (sample_par)  par_mis <= (sample_bit != exp_par);

      if (frame_done) begin
        out_data     <= shift_reg;
        frame_error  <= ~sample_bit;
        parity_error <= parity_en & par_mis;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLOCKS_PER_BIT = 8: vector table plus glitch, break, back-to-back and reset sequences.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial = 1'b1;
  logic [1:0] parity_type = 2'd0;
  logic [7:0] out_data;
  logic       data_valid, parity_error, frame_error;

  uart_rx #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .CLOCK_CTR_WIDTH(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .input_data_serial (serial),
    .parity_type       (parity_type),
    .out_data          (out_data),
    .data_valid        (data_valid),
    .parity_error      (parity_error),
    .frame_error       (frame_error)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Every strobe is logged so multi-frame sequences can be checked afterwards.
  int         vcnt = 0;
  logic [7:0] log_data [64];
  logic       log_pe   [64];
  logic       log_fe   [64];

  always @(negedge clk) begin
    if (data_valid === 1'b1 && vcnt < 64) begin
      log_data[vcnt] = out_data;
      log_pe[vcnt]   = parity_error;
      log_fe[vcnt]   = frame_error;
      vcnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int cycles);
    serial = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic send_frame(input logic [1:0] pt, input logic [1:0] pt_mid, input logic [7:0] d,
                            input logic has_par, input logic par_bit, input logic stop_bit);
    parity_type = pt;
    serial = 1'b0;
    repeat (CPB) @(negedge clk);
    parity_type = pt_mid;
    for (int i = 0; i < 8; i++) begin
      serial = d[i];
      repeat (CPB) @(negedge clk);
    end
    if (has_par) begin
      serial = par_bit;
      repeat (CPB) @(negedge clk);
    end
    serial = stop_bit;
    repeat (CPB) @(negedge clk);
    serial = 1'b1;
  endtask

  task automatic chk_frame(input string name, input int idx, input logic [7:0] d,
                           input logic pe, input logic fe);
    chk({name, "_data"}, 32'(log_data[idx]), 32'(d));
    chk({name, "_perr"}, 32'(log_pe[idx]), 32'(pe));
    chk({name, "_ferr"}, 32'(log_fe[idx]), 32'(fe));
  endtask

  typedef struct {
    logic [1:0] pt;
    logic [1:0] pt_mid;
    logic [7:0] data;
    logic       has_par;
    logic       par_bit;
    logic       stop_bit;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int base;

    //          pt     mid    data   par   pbit  stop  exp    pe    fe
    vecs[0] = '{2'd0, 2'd0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{2'd2, 2'd2, 8'h37, 1'b1, 1'b1, 1'b1, 8'h37, 1'b0, 1'b0};
    vecs[2] = '{2'd2, 2'd2, 8'h37, 1'b1, 1'b0, 1'b1, 8'h37, 1'b1, 1'b0};
    vecs[3] = '{2'd1, 2'd1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{2'd3, 2'd3, 8'hC3, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[5] = '{2'd0, 2'd0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1};
    vecs[6] = '{2'd0, 2'd0, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[7] = '{2'd1, 2'd1, 8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0};
    // parity_type dropped to none mid-frame: the frame must still be checked as even.
    vecs[8] = '{2'd2, 2'd0, 8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[9] = '{2'd0, 2'd0, 8'h66, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0};

    repeat (4) @(negedge clk);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_perr", 32'(parity_error), 32'h0);
    chk("rst_ferr", 32'(frame_error), 32'h0);
    rst_n = 1'b1;
    idle(2 * CPB);

    for (int i = 0; i < 10; i++) begin
      base = vcnt;
      send_frame(vecs[i].pt, vecs[i].pt_mid, vecs[i].data, vecs[i].has_par,
                 vecs[i].par_bit, vecs[i].stop_bit);
      idle(2 * CPB);
      chk($sformatf("vec%0d_pulses", i), 32'(vcnt - base), 32'd1);
      chk_frame($sformatf("vec%0d", i), base, vecs[i].exp_data, vecs[i].exp_pe, vecs[i].exp_fe);
    end

    // Short low glitch on an idle line must not produce a frame.
    parity_type = 2'd0;
    base = vcnt;
    serial = 1'b0;
    repeat (2) @(negedge clk);
    idle(3 * CPB);
    chk("glitch_pulses", 32'(vcnt - base), 32'd0);

    // Back-to-back frames with no idle gap.
    base = vcnt;
    send_frame(2'd0, 2'd0, 8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(2'd0, 2'd0, 8'h22, 1'b0, 1'b0, 1'b1);
    idle(2 * CPB);
    chk("b2b_pulses", 32'(vcnt - base), 32'd2);
    chk_frame("b2b_first", base, 8'h11, 1'b0, 1'b0);
    chk_frame("b2b_second", base + 1, 8'h22, 1'b0, 1'b0);

    // Break: line held low for a whole frame, then released.
    base = vcnt;
    serial = 1'b0;
    repeat (10 * CPB) @(negedge clk);
    idle(3 * CPB);
    chk("break_pulses", 32'(vcnt - base), 32'd1);
    chk_frame("break", base, 8'h00, 1'b0, 1'b1);

    // Leave non-zero outputs behind, then reset in the middle of a 0xFF frame.
    send_frame(2'd0, 2'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
    idle(2 * CPB);
    chk("pre_rst_ferr", 32'(frame_error), 32'h1);
    base = vcnt;
    serial = 1'b0;
    repeat (CPB) @(negedge clk);
    serial = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_data", 32'(out_data), 32'h0);
    chk("midrst_valid", 32'(data_valid), 32'h0);
    chk("midrst_ferr", 32'(frame_error), 32'h0);
    chk("midrst_perr", 32'(parity_error), 32'h0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * CPB);
    send_frame(2'd0, 2'd0, 8'h3C, 1'b0, 1'b0, 1'b1);
    idle(2 * CPB);
    chk("post_rst_pulses", 32'(vcnt - base), 32'd1);
    chk_frame("post_rst", base, 8'h3C, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the team's 8N1/8E1/8O1 UART link.
- Samples the idle-high serial line at bit centres and reassembles data LSB-first.
- Checks optional parity and the stop bit, then presents the byte with a one-cycle valid strobe.
- Sits opposite the existing transmitter and shares its bit timing and parity encoding.

Parameters:
- CLOCKS_PER_BIT, 434: clk cycles per serial bit (50 MHz / 115200).
- DATA_BITS, 8: data bits per frame.
- CLOCK_CTR_WIDTH, 32: width of the bit-timing counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- input_data_serial  input  1  asynchronous serial line, idle high.
- parity_type  input  2  0 = none, 1 = odd, 2 = even, 3 = none.
- out_data  output  DATA_BITS  last received byte.
- data_valid  output  1  one-cycle pulse when a frame completes.
- parity_error  output  1  parity mismatch on the last frame.
- frame_error  output  1  stop bit sampled low on the last frame.

Behaviour:
- Reset values:
  - out_data = 0; data_valid, parity_error, frame_error = 0.
  - Synchroniser flops = 1; state = RX_IDLE; counters = 0.
- Reset is honoured at any time, mid-frame included, and the partial frame is discarded.
- input_data_serial passes through a 2-flop synchroniser. All decisions use the synchronised bit rx_s.
- RX_IDLE:
  - Clear the counters.
  - On rx_s == 0: latch parity_type into parity_reg (values 0 and 3 map to none), then go to RX_START.
- RX_START:
  - Count to (CLOCKS_PER_BIT-1)/2 (integer divide).
  - At that cycle, rx_s == 0 means a valid start: clear the counter, go to RX_DATA.
  - rx_s == 1 means a glitch: return to RX_IDLE with no output change.
- RX_DATA:
  - Count to CLOCKS_PER_BIT-1, then sample rx_s into shift_reg[bit_idx] and clear the counter.
  - After bit DATA_BITS-1: go to RX_PARITY if parity is enabled, else to RX_STOP.
- RX_PARITY:
  - Sample after a full bit period.
  - Expected bit = ^shift_reg for even parity, ~^shift_reg for odd parity.
  - Store the mismatch internally.
- RX_STOP:
  - Sample after a full bit period.
  - In that same cycle:
    - out_data <= shift_reg.
    - frame_error <= ~rx_s.
    - parity_error <= stored mismatch (0 if no parity).
    - data_valid <= 1.
  - Next state is RX_IDLE, so the receiver re-arms mid stop bit.
- data_valid is high for exactly one cycle.
- out_data and the error flags hold until the next frame's strobe.
- A frame with a framing error is still strobed; the consumer decides whether to drop it.
- Latency: data_valid rises about 0.5 bit after the start of the stop bit, plus 2 synchroniser cycles.
- A line held low (break) gives frame_error = 1 and out_data = 0. RX_IDLE then re-detects low immediately and starts a new frame.
- parity_type changes mid-frame are ignored until the next RX_IDLE.
- Any illegal state encoding goes to RX_IDLE.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample (start confirm, data, parity, stop) is the 2-of-3 majority of rx_s at counts centre-1, centre and centre+1.
  - The decision is made at centre+1, shifting valid timing by one cycle.
  - Requires CLOCKS_PER_BIT >= 4.
- Undefined: single sample at centre, as described above.

Decomposition:
- Package uart_pkg:
  - State localparams RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, as a 3-bit encoding.
  - Parity codes PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2.
  - Shared with uart_tx.
- Sub-module uart_sync: a parameterised 2-flop synchroniser with reset value 1, reused for any async line input.

Test Plan (CLOCKS_PER_BIT = 8 unless stated):
- No parity, drive 0xA5 LSB-first with a good stop bit -> one data_valid pulse, out_data = 0xA5, both error flags 0.
- Even parity, 0x37 (five ones) with parity bit 1 -> out_data = 0x37, parity_error = 0. Repeat with parity bit 0 -> parity_error = 1.
- Odd parity, 0x00 with parity bit 1 -> parity_error = 0. Then parity_type = 3 with no parity bit -> treated as none, no error.
- Stop bit driven 0 on 0x5A -> data_valid pulses, out_data = 0x5A, frame_error = 1. The next clean frame 0x0F clears frame_error.
- Low glitch of 2 cycles on idle line -> no data_valid, state back to RX_IDLE. Then back-to-back frames 0x11, 0x22 with no idle gap -> two pulses, both values correct.
- Assert rst_n low during RX_DATA of 0xFF -> outputs are 0 immediately. After release, frame 0x3C is received correctly.
